// File: rtl/quad_step_decoder.sv
// ---------------------------------------------------------------------------
// quad_step_decoder
//
// Turns a two-phase quadrature input (qa/qb) into a one-cycle step pulse plus
// direction, and keeps a wrapping up/down position count. A transition in
// which both phases change together is reported as an error pulse. The error
// is also latched into err_sticky until clr or reset.
//
// Each phase goes through a 2-FF synchronizer. The decoder then compares the
// current Gray state {sa,sb} with the previous one, and the result is
// registered. In the default build, an input level that is stable before
// edge k shows up on step/dir/count at edge k+2.
//
// Build option (macro QDEC_FILTER_EN):
//   When the macro is defined, each synchronized phase also passes through an
//   agreement filter. The filter accepts a new level only after FILT_LEN
//   consecutive identical samples. Latency becomes k+2+FILT_LEN.
//   When the macro is undefined, FILT_LEN has no effect.
//
// Parameters:
//   CNT_W    - width of the position count (wraps modulo 2**CNT_W)
//   FILT_LEN - filter agreement depth (filter build only)
//
// Ports:
//   clk        in   1      clock, posedge
//   reset_n    in   1      asynchronous active-low reset
//   qa, qb     in   1      quadrature phases, asynchronous to clk
//   clr        in   1      synchronous clear of count and err_sticky
//   step       out  1      one-cycle pulse per legal transition
//   dir        out  1      direction of the last step, 1=up 0=down
//   count      out  CNT_W  position count
//   err        out  1      one-cycle pulse per illegal transition
//   err_sticky out  1      latched error flag
// ---------------------------------------------------------------------------
module quad_step_decoder #(
  parameter int CNT_W    = 4,
  parameter int FILT_LEN = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             qa,
  input  logic             qb,
  input  logic             clr,
  output logic             step,
  output logic             dir,
  output logic [CNT_W-1:0] count,
  output logic             err,
  output logic             err_sticky
);

`ifdef QDEC_FILTER_EN
  localparam int FILT_CYC = FILT_LEN;
`else
  // The filter depth does not contribute to the pipeline fill in this build.
  localparam int FILT_CYC = FILT_LEN * 0;
`endif
  // Edges after reset before the compared state reflects real input.
  localparam int INIT_CYC = 2 + FILT_CYC;
  localparam int INIT_W   = $clog2(INIT_CYC + 1);

  // Position of a Gray state along the up sequence 00->01->11->10.
  function automatic logic [1:0] gray_idx(input logic [1:0] s);
    return {s[1], s[1] ^ s[0]};
  endfunction

  logic [1:0]        s1_q, s1_d;        // bit1 = phase A, bit0 = phase B
  logic [1:0]        s2_q, s2_d;
  logic [1:0]        prev_q, prev_d;
  logic              init_q, init_d;
  logic [INIT_W-1:0] init_cnt_q, init_cnt_d;
  logic              step_q, step_d;
  logic              dir_q, dir_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              err_q, err_d;
  logic              sticky_q, sticky_d;
  logic [1:0]        cur;
  logic [1:0]        delta;

`ifdef QDEC_FILTER_EN
  localparam int FCW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  logic [1:0]          filt_q, filt_d;
  logic [1:0][FCW-1:0] fcnt_q, fcnt_d;

  // A phase level is accepted on the FILT_LEN-th consecutive sample that
  // disagrees with the current filtered level. Any agreeing sample restarts
  // the run, so short glitches never reach the decoder.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = fcnt_q;
    for (int i = 0; i < 2; i++) begin
      if (s2_q[i] == filt_q[i]) begin
        fcnt_d[i] = '0;
      end else if (fcnt_q[i] == FCW'(FILT_LEN - 1)) begin
        filt_d[i] = s2_q[i];
        fcnt_d[i] = '0;
      end else begin
        fcnt_d[i] = fcnt_q[i] + FCW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt_q <= '0;
      fcnt_q <= '0;
    end else begin
      filt_q <= filt_d;
      fcnt_q <= fcnt_d;
    end
  end

  assign cur = filt_q;
`else
  assign cur = s2_q;
`endif

  assign delta = gray_idx(cur) - gray_idx(prev_q);

  always_comb begin
    s1_d       = {qa, qb};
    s2_d       = s1_q;
    prev_d     = prev_q;
    init_d     = init_q;
    init_cnt_d = init_cnt_q;
    step_d     = 1'b0;
    err_d      = 1'b0;
    dir_d      = dir_q;
    count_d    = count_q;
    sticky_d   = sticky_q;

    if (!init_q) begin
      // Wait until the pipeline carries real samples, then take the first one
      // as the reference without reporting anything.
      if (init_cnt_q == INIT_W'(INIT_CYC)) begin
        prev_d = cur;
        init_d = 1'b1;
      end else begin
        init_cnt_d = init_cnt_q + INIT_W'(1);
      end
    end else begin
      // Always follow the input, including after an error.
      prev_d = cur;
      unique case (delta)
        2'd1: begin
          step_d  = 1'b1;
          dir_d   = 1'b1;
          count_d = count_q + CNT_W'(1);
        end
        2'd3: begin
          step_d  = 1'b1;
          dir_d   = 1'b0;
          count_d = count_q - CNT_W'(1);
        end
        2'd2: begin
          err_d    = 1'b1;
          sticky_d = 1'b1;
        end
        default: ;
      endcase
    end

    // clr overrides the count and the sticky flag.
    // step, dir and err still report the transition.
    if (clr) begin
      count_d  = '0;
      sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q       <= '0;
      s2_q       <= '0;
      prev_q     <= '0;
      init_q     <= 1'b0;
      init_cnt_q <= '0;
      step_q     <= 1'b0;
      dir_q      <= 1'b0;
      count_q    <= '0;
      err_q      <= 1'b0;
      sticky_q   <= 1'b0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      prev_q     <= prev_d;
      init_q     <= init_d;
      init_cnt_q <= init_cnt_d;
      step_q     <= step_d;
      dir_q      <= dir_d;
      count_q    <= count_d;
      err_q      <= err_d;
      sticky_q   <= sticky_d;
    end
  end

  assign step       = step_q;
  assign dir        = dir_q;
  assign count      = count_q;
  assign err        = err_q;
  assign err_sticky = sticky_q;

endmodule
